// File: rtl/absolute_value_pipelined.sv
// Alpha-max-beta-min magnitude estimator for |re + j*im|.
// Three-stage pipeline with a clock-enable stall and a valid sideband,
// a coefficient set selected per sample, and a per-frame peak tracker
// that reports the largest magnitude and its 0-based index in the frame.
module absolute_value_pipelined #(
    parameter int DATA_WIDTH = 18,
    parameter int FRAME_LEN  = 1024,
    parameter int IDX_WIDTH  = $clog2(FRAME_LEN)
) (
    input  logic                         clock,
    input  logic                         resetN,
    input  logic                         enable,
    input  logic                         validIn,
    input  logic [1:0]                   mode,
    input  logic signed [DATA_WIDTH-1:0] dataInRe,
    input  logic signed [DATA_WIDTH-1:0] dataInIm,
    output logic                         validOut,
    output logic signed [DATA_WIDTH:0]   dataOut,
    output logic                         peakValid,
    output logic signed [DATA_WIDTH:0]   peakValue,
    output logic [IDX_WIDTH-1:0]         peakIndex
);

    localparam logic [DATA_WIDTH-1:0] ONE_DW   = DATA_WIDTH'(1);
    localparam logic [IDX_WIDTH-1:0]  CNT_LAST = IDX_WIDTH'(FRAME_LEN - 1);
    localparam logic [IDX_WIDTH-1:0]  CNT_ONE  = IDX_WIDTH'(1);

    // Stage 1: absolute values (unsigned, so the most negative input is exact)
    logic [DATA_WIDTH-1:0] re_u, im_u;
    logic [DATA_WIDTH-1:0] a_d, b_d, a_q, b_q;
    logic                  vld1_q;
    logic [1:0]            mode1_q;

    // Stage 2: ordered pair
    logic [DATA_WIDTH-1:0] mx_d, mn_d, mx_q, mn_q;
    logic                  vld2_q;
    logic [1:0]            mode2_q;

    // Stage 3: magnitude estimate
    logic [DATA_WIDTH:0]   mx_w, mn_w, sum_d;
    logic signed [DATA_WIDTH:0] data_q;
    logic                  vld3_q;

    // Peak tracker
    logic [DATA_WIDTH:0]   mag_u;
    logic [IDX_WIDTH-1:0]  cnt_d, cnt_q;
    logic [DATA_WIDTH:0]   pv_d, pv_q;
    logic [IDX_WIDTH-1:0]  pi_d, pi_q;
    logic [DATA_WIDTH:0]   cand_v;
    logic [IDX_WIDTH-1:0]  cand_i;
    logic [DATA_WIDTH:0]   pk_val_d, pk_val_q;
    logic [IDX_WIDTH-1:0]  pk_idx_d, pk_idx_q;
    logic                  pk_vld_d, pk_vld_q;

    assign re_u = dataInRe;
    assign im_u = dataInIm;

    // Two's-complement negate in unsigned DATA_WIDTH bits; -2^(N-1) maps to 2^(N-1)
    always_comb begin
        a_d = re_u;
        b_d = im_u;
        if (re_u[DATA_WIDTH-1]) a_d = (~re_u) + ONE_DW;
        if (im_u[DATA_WIDTH-1]) b_d = (~im_u) + ONE_DW;
    end

    // Stage 1 registers
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            a_q     <= '0;
            b_q     <= '0;
            vld1_q  <= 1'b0;
            mode1_q <= 2'd0;
        end else if (enable) begin
            a_q     <= a_d;
            b_q     <= b_d;
            vld1_q  <= validIn;
            mode1_q <= mode;
        end
    end

    // Order the pair; on a tie mx takes a
    always_comb begin
        mx_d = a_q;
        mn_d = b_q;
        if (b_q > a_q) begin
            mx_d = b_q;
            mn_d = a_q;
        end
    end

    // Stage 2 registers
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            mx_q    <= '0;
            mn_q    <= '0;
            vld2_q  <= 1'b0;
            mode2_q <= 2'd0;
        end else if (enable) begin
            mx_q    <= mx_d;
            mn_q    <= mn_d;
            vld2_q  <= vld1_q;
            mode2_q <= mode1_q;
        end
    end

    // Coefficient sets; every shifted term is floored on its own
    always_comb begin
        mx_w = {1'b0, mx_q};
        mn_w = {1'b0, mn_q};
        unique case (mode2_q)
            2'd0:    sum_d = mx_w + (mn_w >> 2);
            2'd1:    sum_d = mx_w + (mn_w >> 2) + (mn_w >> 3);
            2'd2:    sum_d = mx_w - (mx_w >> 4) + (mn_w >> 1) - (mn_w >> 5);
            default: sum_d = mx_w + (mn_w >> 1);
        endcase
    end

    // Stage 3 registers; the result never exceeds 1.5*2^(N-1), so bit N stays 0
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            data_q <= '0;
            vld3_q <= 1'b0;
        end else if (enable) begin
            data_q <= $signed(sum_d);
            vld3_q <= vld2_q;
        end
    end

    assign mag_u = data_q;

    // Running peak: index 0 loads unconditionally, later samples need strictly greater
    always_comb begin
        cnt_d    = cnt_q;
        pv_d     = pv_q;
        pi_d     = pi_q;
        pk_val_d = pk_val_q;
        pk_idx_d = pk_idx_q;
        pk_vld_d = 1'b0;
        cand_v   = pv_q;
        cand_i   = pi_q;
        if (cnt_q == '0 || mag_u > pv_q) begin
            cand_v = mag_u;
            cand_i = cnt_q;
        end
        if (vld3_q) begin
            pv_d = cand_v;
            pi_d = cand_i;
            if (cnt_q == CNT_LAST) begin
                cnt_d    = '0;
                pk_val_d = cand_v;
                pk_idx_d = cand_i;
                pk_vld_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    // Peak tracker registers; the frame-end pulse lasts one enabled edge
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            cnt_q    <= '0;
            pv_q     <= '0;
            pi_q     <= '0;
            pk_val_q <= '0;
            pk_idx_q <= '0;
            pk_vld_q <= 1'b0;
        end else if (enable) begin
            cnt_q    <= cnt_d;
            pv_q     <= pv_d;
            pi_q     <= pi_d;
            pk_val_q <= pk_val_d;
            pk_idx_q <= pk_idx_d;
            pk_vld_q <= pk_vld_d;
        end
    end

    assign validOut  = vld3_q;
    assign dataOut   = data_q;
    assign peakValid = pk_vld_q;
    assign peakValue = $signed(pk_val_q);
    assign peakIndex = pk_idx_q;

endmodule

// File: tb/tb_absolute_value_pipelined.sv
module tb_absolute_value_pipelined;

    localparam int DW = 18;
    localparam int FL = 4;
    localparam int IW = 2;

    logic                 clock;
    logic                 resetN;
    logic                 enable;
    logic                 validIn;
    logic [1:0]           mode;
    logic signed [DW-1:0] dataInRe;
    logic signed [DW-1:0] dataInIm;
    logic                 validOut;
    logic signed [DW:0]   dataOut;
    logic                 peakValid;
    logic signed [DW:0]   peakValue;
    logic [IW-1:0]        peakIndex;

    int checks   = 0;
    int failures = 0;

    absolute_value_pipelined #(
        .DATA_WIDTH(DW),
        .FRAME_LEN (FL)
    ) dut (
        .clock    (clock),
        .resetN   (resetN),
        .enable   (enable),
        .validIn  (validIn),
        .mode     (mode),
        .dataInRe (dataInRe),
        .dataInIm (dataInIm),
        .validOut (validOut),
        .dataOut  (dataOut),
        .peakValid(peakValid),
        .peakValue(peakValue),
        .peakIndex(peakIndex)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input int r, input int i, input int m);
        validIn  = v;
        dataInRe = r[DW-1:0];
        dataInIm = i[DW-1:0];
        mode     = m[1:0];
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int model(input int re, input int im, input int m);
        int a, b, mx, mn;
        a  = (re < 0) ? -re : re;
        b  = (im < 0) ? -im : im;
        mx = (a >= b) ? a : b;
        mn = (a >= b) ? b : a;
        case (m)
            0:       return mx + (mn >> 2);
            1:       return mx + (mn >> 2) + (mn >> 3);
            2:       return mx - (mx >> 4) + (mn >> 1) - (mn >> 5);
            default: return mx + (mn >> 1);
        endcase
    endfunction

    int fr_re  [8] = '{3, 100, 0, 8, 9, 2, -9, 3};
    int fr_im  [8] = '{4, 0, -100, 8, 0, 0, 0, 0};
    int fr_exp [8] = '{4, 100, 100, 10, 9, 2, 9, 3};
    int sw_exp [4] = '{15697, 15704, 14731, 15712};
    int ng_re  [3] = '{-131072, -131000, 0};
    int ng_im  [3] = '{-131072, 69420, -1357};
    int ng_m   [3] = '{3, 0, 0};
    int ng_exp [3] = '{196608, 148355, 1357};
    int rs_exp [4] = '{1, 2, 3, 2};
    int st_re  [20];
    int st_im  [20];
    logic st_v [20];

    initial begin
        resetN  = 1'b0;
        enable  = 1'b1;
        drive(0, 0, 0, 0);
        repeat (2) tick;
        chk("rst_validOut", validOut, 0);
        chk("rst_dataOut", dataOut, 0);
        chk("rst_peakValid", peakValid, 0);
        chk("rst_peakValue", peakValue, 0);
        chk("rst_peakIndex", peakIndex, 0);
        resetN = 1'b1;

        // Two back-to-back frames: peak 100@1 (tie keeps first), then 9@0
        for (int s = 0; s < 12; s++) begin
            if (s < 8) drive(1, fr_re[s], fr_im[s], 0);
            else       drive(0, 0, 0, 0);
            tick;
            if (s >= 2 && s < 10) begin
                chk($sformatf("frame_valid_%0d", s - 2), validOut, 1);
                chk($sformatf("frame_data_%0d", s - 2), dataOut, fr_exp[s - 2]);
            end
            if (s >= 10) chk($sformatf("frame_tail_valid_%0d", s), validOut, 0);
            if (s == 6) begin
                chk("frame1_peakValid", peakValid, 1);
                chk("frame1_peakValue", peakValue, 100);
                chk("frame1_peakIndex", peakIndex, 1);
            end else if (s == 10) begin
                chk("frame2_peakValid", peakValid, 1);
                chk("frame2_peakValue", peakValue, 9);
                chk("frame2_peakIndex", peakIndex, 0);
            end else begin
                chk($sformatf("frame_nopulse_%0d", s), peakValid, 0);
            end
        end
        chk("frame2_peak_hold", peakValue, 9);

        // Mid-frame reset with a sample still in flight
        drive(1, 60, 0, 0); tick;
        drive(1, 70, 0, 0); tick;
        drive(1, 80, 0, 0); tick;
        drive(0, 0, 0, 0);  tick;
        chk("pre_rst_valid", validOut, 1);
        chk("pre_rst_data", dataOut, 70);
        #2;
        resetN = 1'b0;
        #1;
        chk("async_rst_validOut", validOut, 0);
        chk("async_rst_dataOut", dataOut, 0);
        chk("async_rst_peakValue", peakValue, 0);
        chk("async_rst_peakIndex", peakIndex, 0);
        chk("async_rst_peakValid", peakValid, 0);
        tick;
        resetN = 1'b1;
        for (int s = 0; s < 8; s++) begin
            if (s < 4) drive(1, rs_exp[s], 0, 0);
            else       drive(0, 0, 0, 0);
            tick;
            if (s < 2 || s >= 6) chk($sformatf("post_rst_idle_%0d", s), validOut, 0);
            else begin
                chk($sformatf("post_rst_valid_%0d", s - 2), validOut, 1);
                chk($sformatf("post_rst_data_%0d", s - 2), dataOut, rs_exp[s - 2]);
            end
            if (s == 6) begin
                chk("post_rst_peakValid", peakValid, 1);
                chk("post_rst_peakValue", peakValue, 3);
                chk("post_rst_peakIndex", peakIndex, 2);
            end else begin
                chk($sformatf("post_rst_nopulse_%0d", s), peakValid, 0);
            end
        end

        // Mode sweep: result after exactly three enabled edges, valid for one cycle
        for (int m = 0; m < 4; m++) begin
            drive(1, 59, 15683, m); tick;
            chk($sformatf("sweep%0d_lat1", m), validOut, 0);
            drive(0, 0, 0, 0); tick;
            chk($sformatf("sweep%0d_lat2", m), validOut, 0);
            tick;
            chk($sformatf("sweep%0d_valid", m), validOut, 1);
            chk($sformatf("sweep%0d_data", m), dataOut, sw_exp[m]);
            tick;
            chk($sformatf("sweep%0d_after", m), validOut, 0);
        end

        // Negative extremes back-to-back
        for (int s = 0; s < 5; s++) begin
            if (s < 3) drive(1, ng_re[s], ng_im[s], ng_m[s]);
            else       drive(0, 0, 0, 0);
            tick;
            if (s >= 2) begin
                chk($sformatf("neg_valid_%0d", s - 2), validOut, 1);
                chk($sformatf("neg_data_%0d", s - 2), dataOut, ng_exp[s - 2]);
            end
        end

        // Stream with bubbles every 5th sample, mode changing each sample, and an enable gap
        for (int i = 0; i < 20; i++) begin
            st_re[i] = ((i * 37771) % 200001) - 100000;
            st_im[i] = 60000 - i * 6007;
            st_v[i]  = (i % 5) != 4;
        end
        for (int s = 0; s < 22; s++) begin
            if (s < 20) drive(st_v[s], st_re[s], st_im[s], s % 4);
            else        drive(0, 0, 0, 0);
            tick;
            if (s >= 2) begin
                chk($sformatf("stream_valid_%0d", s - 2), validOut, st_v[s - 2]);
                if (st_v[s - 2])
                    chk($sformatf("stream_data_%0d", s - 2), dataOut,
                        model(st_re[s - 2], st_im[s - 2], (s - 2) % 4));
            end
            if (s == 10) begin
                enable = 1'b0;
                for (int g = 0; g < 4; g++) begin
                    drive(1, 1000 + g, -777, g);
                    tick;
                    chk($sformatf("stall_valid_%0d", g), validOut, 1);
                    chk($sformatf("stall_data_%0d", g), dataOut, model(st_re[8], st_im[8], 0));
                end
                enable = 1'b1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/absolute_value_pipelined.md
Name: absolute_value_pipelined

Overview:
- Parametrised successor to the single-mode complex magnitude block. Computes an alpha-max-beta-min approximation of |re + j·im|.
- Coefficient set is selectable at run time per sample. The pipeline has a valid handshake and an enable stall.
- A per-frame peak tracker reports the largest magnitude and its sample index.
- Sits after the matched-filter/pulse-compression output and feeds threshold/detection logic.

Parameters:
- DATA_WIDTH, 18, signed width of each input component; output is DATA_WIDTH+1 signed.
- FRAME_LEN, 1024, valid output samples per peak-search frame (>=2).
- IDX_WIDTH, $clog2(FRAME_LEN), width of the counter and the peak index.

Ports:
- clock  in  1  system clock, rising-edge.
- resetN  in  1  asynchronous, active-low reset.
- enable  in  1  pipeline clock-enable; 0 = every register holds.
- validIn  in  1  dataInRe/dataInIm/mode carry a sample this cycle.
- mode  in  2  coefficient set, sampled with the data.
- dataInRe  in  DATA_WIDTH  signed real part.
- dataInIm  in  DATA_WIDTH  signed imaginary part.
- validOut  out  1  dataOut is valid.
- dataOut  out  DATA_WIDTH+1  signed magnitude, always >=0.
- peakValid  out  1  one-cycle pulse at frame end.
- peakValue  out  DATA_WIDTH+1  largest dataOut in the completed frame.
- peakIndex  out  IDX_WIDTH  position of that sample within the frame (0-based).

Behaviour:
- Reset (resetN=0, async):
  - All pipeline registers, validOut, dataOut, peakValid, peakValue, peakIndex, the frame counter and the running peak clear to 0 immediately.
  - A mid-frame reset discards the partial frame. The first valid output after release is index 0.
- Pipeline (3 stages, each advancing only when enable=1):
  - S1: register a=|re| and b=|im| as DATA_WIDTH-bit unsigned values. |-2^(DATA_WIDTH-1)| = 2^(DATA_WIDTH-1) must be exact, with no overflow. Also register validIn and mode.
  - S2: register mx=max(a,b) and mn=min(a,b). When a==b, mx=a.
  - S3: register dataOut from mx and mn, plus validOut. All shifts are logical right shifts of unsigned values and each term is floored independently:
    - mode 0: mx + (mn>>2)
    - mode 1: mx + (mn>>2) + (mn>>3)
    - mode 2: mx - (mx>>4) + (mn>>1) - (mn>>5)
    - mode 3: mx + (mn>>1)
  - Intermediate sums use DATA_WIDTH+1 bits. The maximum result is 1.5·2^(DATA_WIDTH-1), which fits without saturation.
- Latency: a sample presented at enabled edge k appears on dataOut/validOut after enabled edge k+2, i.e. 3 enabled edges.
- When enable=0, all outputs hold their previous values, including validOut and peakValid. enable gaps must not drop or duplicate samples.
- validIn=0 bubbles propagate as validOut=0. dataOut keeps being computed from the registered data but must not be used.
- Mode may change every sample. Each sample uses the mode registered with it.
- Peak tracker (updates on enabled edges where the S3 result is valid):
  - Counter cnt runs 0..FRAME_LEN-1. The running peak (pv, pi) is replaced only if the new value is strictly greater than pv, so on a tie the first occurrence wins. At cnt=0, pv/pi load unconditionally.
  - When cnt==FRAME_LEN-1, the final comparison is included and the result is copied to peakValue/peakIndex. peakValid=1 on the following enabled edge only, then returns to 0 on the next enabled edge. The counter wraps to 0 and a new frame starts with no dead cycles.
  - peakValue and peakIndex hold until the next frame end.

Test Plan:
- Mode sweep, DATA_WIDTH=18, re=59, im=15683: mode0->15697, mode1->15704, mode2->14731, mode3->15712. Each appears exactly 3 enabled edges after input, with validOut=1 for one cycle.
- Negative extremes: (-131072,-131072) mode3 -> 196608; (-131000,69420) mode0 -> 148355; (0,-1357) mode0 -> 1357. No sign errors.
- Back-to-back stream of 20 samples with the mode toggling each cycle and a validIn bubble every 5th cycle: the output matches a golden model sample-for-sample and each bubble appears 3 cycles later.
- enable low for 4 cycles mid-stream: outputs and validOut freeze. On resume the sequence continues with no loss or duplication.
- FRAME_LEN=4, mode0, inputs (3,4),(100,0),(0,-100),(8,8): dataOut 4,100,100,10; peakValid pulses once with peakValue=100 and peakIndex=1. The next frame starts at index 0.
- Reset asserted after the 2nd sample of a frame: outputs clear immediately. After release, a fresh 4-sample frame reports correctly with no stale peak.
